// File: rtl/d16_wb_timer_pkg.sv
// Shared constants for the d16 Wishbone timer: register offsets and
// bit positions inside the CTRL and STATUS registers.
package d16_pkg;

  // Register offsets within the 8-word window
  localparam logic [2:0] TMR_CTRL     = 3'd0;
  localparam logic [2:0] TMR_PRESCALE = 3'd1;
  localparam logic [2:0] TMR_COUNT    = 3'd2;
  localparam logic [2:0] TMR_COMPARE  = 3'd3;
  localparam logic [2:0] TMR_STATUS   = 3'd4;
  localparam logic [2:0] TMR_CAPTURE  = 3'd5;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IE     = 2;

  // STATUS bit positions (all write-1-to-clear)
  localparam int STAT_PEND = 0;
  localparam int STAT_OVF  = 1;
  localparam int STAT_CAP  = 2;

  // Implemented widths of CTRL and STATUS
  localparam int CTRL_W = 3;
  localparam int STAT_W = 3;

endpackage

// File: rtl/d16_wb_timer_if.sv
// Wishbone target bus for the d16 timer. Signal names follow the CPU-side
// port names; the CPU (or testbench) is the master.
interface d16_wb_timer_if;
  logic [15:0] i_wb_addr;
  logic        i_wb_cyc;
  logic        i_wb_we;
  logic [15:0] i_wb_dat;
  logic [15:0] o_wb_dat;

  modport master (
    output i_wb_addr, i_wb_cyc, i_wb_we, i_wb_dat,
    input  o_wb_dat
  );

  modport slave (
    input  i_wb_addr, i_wb_cyc, i_wb_we, i_wb_dat,
    output o_wb_dat
  );
endinterface

// File: rtl/d16_wb_timer_prescaler.sv
// Prescaler for the d16 timer: emits a one-cycle tick every limit+1 cycles
// while enabled. The counter is held at 0 while disabled or when cleared.
module d16_prescaler
  import d16_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        enable,
  input  logic [15:0] limit,
  input  logic        clear,
  output logic        tick
);

  logic [15:0] pcnt_q, pcnt_d;

  // Tick when the count reaches the limit, then restart from 0
  always_comb begin
    tick   = enable && (pcnt_q == limit);
    pcnt_d = pcnt_q + 16'd1;
    if (!enable || clear || tick) pcnt_d = '0;
  end

  // Prescaler counter register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) pcnt_q <= '0;
    else         pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/d16_wb_timer.sv
// d16 Wishbone timer: 16-bit counter with prescaler, compare match,
// overflow detection and a level interrupt. Reads are combinational,
// writes land on the clock edge ending the access.
// Optional input capture is built when D16_TIMER_CAPTURE_EN is defined.
module d16_wb_timer
  import d16_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic             i_clk,
  input  logic             i_reset,
  d16_wb_timer_if.slave    wb,
  output logic             o_int
`ifdef D16_TIMER_CAPTURE_EN
  ,
  input  logic             i_capture
`endif
);

  logic              sel, wr, rd, tick, match, cap_rise;
  logic [2:0]        off;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [15:0]       prescale_q, prescale_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       compare_q, compare_d;
  logic [STAT_W-1:0] status_q, status_d, stat_set, stat_clr;

  assign sel   = wb.i_wb_cyc && (wb.i_wb_addr[15:3] == BASE_ADDR[15:3]);
  assign off   = wb.i_wb_addr[2:0];
  assign wr    = sel && wb.i_wb_we;
  assign rd    = sel && !wb.i_wb_we;
  assign match = (count_q == compare_q);

  d16_prescaler u_prescaler (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .enable  (ctrl_q[CTRL_EN]),
    .limit   (prescale_q),
    .clear   (wr && (off == TMR_PRESCALE)),
    .tick    (tick)
  );

`ifdef D16_TIMER_CAPTURE_EN
  logic [1:0]  cap_sync_q, cap_sync_d;
  logic        cap_prev_q, cap_prev_d;
  logic [15:0] capture_q, capture_d;

  // Synchronize the capture pin and latch COUNT on its rising edge
  always_comb begin
    cap_sync_d = {cap_sync_q[0], i_capture};
    cap_prev_d = cap_sync_q[1];
    cap_rise   = cap_sync_q[1] && !cap_prev_q;
    capture_d  = cap_rise ? count_q : capture_q;
  end

  // Capture synchronizer, edge detector and capture register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cap_sync_q <= '0;
      cap_prev_q <= 1'b0;
      capture_q  <= '0;
    end else begin
      cap_sync_q <= cap_sync_d;
      cap_prev_q <= cap_prev_d;
      capture_q  <= capture_d;
    end
  end
`else
  assign cap_rise = 1'b0;
`endif

  // Counter/compare behaviour on tick, then CPU writes override it
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    compare_d  = compare_q;
    stat_set   = '0;
    stat_clr   = '0;

    if (tick) begin
      if (match) begin
        stat_set[STAT_PEND] = 1'b1;
        if (ctrl_q[CTRL_RELOAD]) count_d = '0;
        else                     ctrl_d[CTRL_EN] = 1'b0;
      end else if (count_q == 16'hFFFF) begin
        count_d            = '0;
        stat_set[STAT_OVF] = 1'b1;
      end else begin
        count_d = count_q + 16'd1;
      end
    end

    if (cap_rise) stat_set[STAT_CAP] = 1'b1;

    if (wr) begin
      case (off)
        TMR_CTRL:     ctrl_d     = wb.i_wb_dat[CTRL_W-1:0];
        TMR_PRESCALE: prescale_d = wb.i_wb_dat;
        TMR_COUNT:    count_d    = wb.i_wb_dat;
        TMR_COMPARE:  compare_d  = wb.i_wb_dat;
        TMR_STATUS:   stat_clr   = wb.i_wb_dat[STAT_W-1:0];
        default:      ;
      endcase
    end

    // A hardware set wins over a same-cycle clear so no event is lost
    status_d = (status_q & ~stat_clr) | stat_set;
  end

  // Timer register file
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      count_q    <= '0;
      compare_q  <= 16'hFFFF;
      status_q   <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
    end
  end

  // Zero-latency read mux, driving 0 when not selected for an OR-ed bus
  always_comb begin
    wb.o_wb_dat = '0;
    if (rd) begin
      case (off)
        TMR_CTRL:     wb.o_wb_dat = {{(16-CTRL_W){1'b0}}, ctrl_q};
        TMR_PRESCALE: wb.o_wb_dat = prescale_q;
        TMR_COUNT:    wb.o_wb_dat = count_q;
        TMR_COMPARE:  wb.o_wb_dat = compare_q;
        TMR_STATUS:   wb.o_wb_dat = {{(16-STAT_W){1'b0}}, status_q};
`ifdef D16_TIMER_CAPTURE_EN
        TMR_CAPTURE:  wb.o_wb_dat = capture_q;
`endif
        default:      wb.o_wb_dat = '0;
      endcase
    end
  end

  // Level interrupt from any pending status flag, gated by IE
  assign o_int = ctrl_q[CTRL_IE] && (|status_q);

endmodule

// File: tb/tb_d16_wb_timer.sv
// Directed testbench for d16_wb_timer. Inputs change and outputs are
// sampled in the low phase of the clock, away from the rising edge.
module tb_d16_wb_timer;
  import d16_pkg::*;

  localparam logic [15:0] BASE = 16'hFF00;

  logic i_clk;
  logic i_reset;
  logic o_int;
`ifdef D16_TIMER_CAPTURE_EN
  logic i_capture;
`endif

  int tests_run;
  int tests_failed;

  d16_wb_timer_if wb ();

  d16_wb_timer #(.BASE_ADDR(BASE)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .wb        (wb),
    .o_int     (o_int)
`ifdef D16_TIMER_CAPTURE_EN
    ,
    .i_capture (i_capture)
`endif
  );

  initial i_clk = 1'b0;
  always #10 i_clk = ~i_clk;

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One write access; returns at the falling edge after the write edge
  task automatic apply_stimulus(input logic [2:0] offset, input logic [15:0] data);
    wb.i_wb_addr = BASE | {13'd0, offset};
    wb.i_wb_dat  = data;
    wb.i_wb_we   = 1'b1;
    wb.i_wb_cyc  = 1'b1;
    @(negedge i_clk);
    wb.i_wb_cyc  = 1'b0;
    wb.i_wb_we   = 1'b0;
  endtask

  task automatic read_check(input logic [2:0] offset, input logic [15:0] expected,
                            input string tag);
    wb.i_wb_addr = BASE | {13'd0, offset};
    wb.i_wb_we   = 1'b0;
    wb.i_wb_cyc  = 1'b1;
    #1;
    check_output(tag, wb.o_wb_dat, expected);
    wb.i_wb_cyc  = 1'b0;
  endtask

  task automatic int_check(input logic expected, input string tag);
    check_output(tag, {15'd0, o_int}, {15'd0, expected});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    i_reset      = 1'b1;
    wb.i_wb_addr = '0;
    wb.i_wb_cyc  = 1'b0;
    wb.i_wb_we   = 1'b0;
    wb.i_wb_dat  = '0;
`ifdef D16_TIMER_CAPTURE_EN
    i_capture    = 1'b0;
`endif
    step(2);
    i_reset = 1'b0;

    // Reset values
    read_check(TMR_CTRL,     16'h0000, "rst_ctrl");
    read_check(TMR_PRESCALE, 16'h0000, "rst_prescale");
    read_check(TMR_COUNT,    16'h0000, "rst_count");
    read_check(TMR_COMPARE,  16'hFFFF, "rst_compare");
    read_check(TMR_STATUS,   16'h0000, "rst_status");
    read_check(3'd6,         16'h0000, "rst_reserved6");
    int_check(1'b0, "rst_int");
    wb.i_wb_addr = BASE | 16'd3;
    wb.i_wb_cyc  = 1'b0;
    #1;
    check_output("unselected_read", wb.o_wb_dat, 16'h0000);
    step(1);

    // Periodic mode: PRESCALE=0, COMPARE=3, CTRL=EN|RELOAD|IE
    apply_stimulus(TMR_PRESCALE, 16'd0);
    apply_stimulus(TMR_COMPARE, 16'd3);
    read_check(TMR_COMPARE, 16'd3, "per_compare");
    apply_stimulus(TMR_CTRL, 16'd7);
    read_check(TMR_COUNT, 16'd0, "per_count0");
    read_check(TMR_CTRL, 16'd7, "per_ctrl");
    step(1);
    read_check(TMR_COUNT, 16'd1, "per_count1");
    step(1);
    read_check(TMR_COUNT, 16'd2, "per_count2");
    step(1);
    read_check(TMR_COUNT, 16'd3, "per_count3");
    int_check(1'b0, "per_int_before");
    step(1);
    read_check(TMR_COUNT, 16'd0, "per_count_wrap");
    read_check(TMR_STATUS, 16'd1, "per_pend");
    int_check(1'b1, "per_int_match");
    apply_stimulus(TMR_STATUS, 16'd1);
    read_check(TMR_STATUS, 16'd0, "per_w1c");
    int_check(1'b0, "per_int_cleared");
    read_check(TMR_COUNT, 16'd1, "per_count_after_w1c");
    step(2);
    read_check(TMR_COUNT, 16'd3, "per_count3_again");
    // Clear PEND in the same cycle as a new match: the set wins
    apply_stimulus(TMR_STATUS, 16'd1);
    read_check(TMR_STATUS, 16'd1, "w1c_vs_set");
    read_check(TMR_COUNT, 16'd0, "w1c_vs_set_count");
    // COUNT write in a tick cycle beats the increment
    apply_stimulus(TMR_COUNT, 16'd100);
    read_check(TMR_COUNT, 16'd100, "count_write_vs_tick");
    step(1);
    read_check(TMR_COUNT, 16'd101, "count_after_write");
    apply_stimulus(TMR_CTRL, 16'd0);
    read_check(TMR_CTRL, 16'd0, "disable_ctrl");
    int_check(1'b0, "ie_off_int");
    step(2);
    read_check(TMR_COUNT, 16'd102, "disable_hold");

    // One-shot: PRESCALE=2, COMPARE=1, CTRL=EN
    apply_stimulus(TMR_STATUS, 16'd3);
    apply_stimulus(TMR_PRESCALE, 16'd2);
    apply_stimulus(TMR_COMPARE, 16'd1);
    apply_stimulus(TMR_COUNT, 16'd0);
    read_check(TMR_STATUS, 16'd0, "os_status_clr");
    apply_stimulus(TMR_CTRL, 16'd1);
    read_check(TMR_COUNT, 16'd0, "os_count_start");
    step(2);
    read_check(TMR_COUNT, 16'd0, "os_count_pre_tick");
    step(1);
    read_check(TMR_COUNT, 16'd1, "os_count_tick1");
    step(2);
    read_check(TMR_COUNT, 16'd1, "os_count_pre_match");
    read_check(TMR_STATUS, 16'd0, "os_status_pre_match");
    step(1);
    read_check(TMR_STATUS, 16'd1, "os_pend");
    read_check(TMR_CTRL, 16'd0, "os_en_cleared");
    read_check(TMR_COUNT, 16'd1, "os_count_match");
    int_check(1'b0, "os_int_no_ie");
    step(5);
    read_check(TMR_COUNT, 16'd1, "os_count_hold");

    // Match at FFFF takes priority over wrap
    apply_stimulus(TMR_STATUS, 16'd3);
    apply_stimulus(TMR_PRESCALE, 16'd0);
    apply_stimulus(TMR_COMPARE, 16'hFFFF);
    apply_stimulus(TMR_COUNT, 16'hFFFE);
    apply_stimulus(TMR_CTRL, 16'd5);
    read_check(TMR_COUNT, 16'hFFFE, "ffff_count_start");
    step(1);
    read_check(TMR_COUNT, 16'hFFFF, "ffff_count_top");
    step(1);
    read_check(TMR_STATUS, 16'd1, "ffff_pend_no_ovf");
    read_check(TMR_COUNT, 16'hFFFF, "ffff_count_hold");
    read_check(TMR_CTRL, 16'd4, "ffff_en_cleared");
    int_check(1'b1, "ffff_int");

    // Wrap from FFFF sets OVF
    apply_stimulus(TMR_STATUS, 16'd3);
    int_check(1'b0, "ovf_int_cleared");
    apply_stimulus(TMR_COMPARE, 16'd10);
    apply_stimulus(TMR_COUNT, 16'hFFFF);
    apply_stimulus(TMR_CTRL, 16'd5);
    read_check(TMR_COUNT, 16'hFFFF, "ovf_count_start");
    read_check(TMR_STATUS, 16'd0, "ovf_status_pre");
    step(1);
    read_check(TMR_COUNT, 16'd0, "ovf_count_wrap");
    read_check(TMR_STATUS, 16'd2, "ovf_set");
    int_check(1'b1, "ovf_int");
    apply_stimulus(TMR_CTRL, 16'd4);
    read_check(TMR_CTRL, 16'd4, "ovf_ctrl_ie_only");
    int_check(1'b1, "ovf_int_ie_only");
    step(1);
    read_check(TMR_COUNT, 16'd1, "ovf_count_stopped");
    apply_stimulus(TMR_CTRL, 16'd0);
    int_check(1'b0, "ie_clear_int");
    read_check(TMR_STATUS, 16'd2, "ovf_status_kept");

    // Address decode and reserved registers
    wb.i_wb_addr = 16'h0002;
    wb.i_wb_we   = 1'b0;
    wb.i_wb_cyc  = 1'b1;
    #1;
    check_output("out_of_window", wb.o_wb_dat, 16'h0000);
    wb.i_wb_cyc  = 1'b0;
    apply_stimulus(3'd7, 16'hFFFF);
    read_check(3'd7, 16'h0000, "reserved7_write");
`ifndef D16_TIMER_CAPTURE_EN
    read_check(TMR_CAPTURE, 16'h0000, "no_capture_reg");
`endif

    // Asynchronous reset while counting
    apply_stimulus(TMR_CTRL, 16'd5);
    int_check(1'b1, "pre_reset_int");
    #3;
    i_reset = 1'b1;
    #1;
    int_check(1'b0, "async_rst_int");
    read_check(TMR_COUNT,   16'd0,    "async_rst_count");
    read_check(TMR_STATUS,  16'd0,    "async_rst_status");
    read_check(TMR_COMPARE, 16'hFFFF, "async_rst_compare");
    read_check(TMR_CTRL,    16'd0,    "async_rst_ctrl");
    step(1);
    i_reset = 1'b0;

`ifdef D16_TIMER_CAPTURE_EN
    // Capture COUNT three cycles after the pin rises
    apply_stimulus(TMR_COUNT, 16'd20);
    apply_stimulus(TMR_CTRL, 16'd1);
    i_capture = 1'b1;
    read_check(TMR_COUNT, 16'd20, "cap_count_start");
    step(1);
    i_capture = 1'b0;
    step(1);
    read_check(TMR_STATUS, 16'd0, "cap_status_pre");
    step(1);
    read_check(TMR_CAPTURE, 16'd22, "cap_value");
    read_check(TMR_STATUS, 16'd4, "cap_flag");
    read_check(TMR_COUNT, 16'd23, "cap_count_now");
    int_check(1'b0, "cap_int_no_ie");
    apply_stimulus(TMR_CTRL, 16'd4);
    int_check(1'b1, "cap_int_ie");
    apply_stimulus(TMR_STATUS, 16'd4);
    int_check(1'b0, "cap_w1c_int");
    read_check(TMR_CAPTURE, 16'd22, "cap_value_hold");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
